receive: RTL and testbench
==========================

// Module: receive
// PURPOSE
//  Downstream partner of transmit: requests an instruction stream with r_o_syn, captures each
//  acknowledged word into an internal instruction buffer, and detects end-of-program via last.
//  After loading, the buffer is read by the fetch stage through a registered read port.
//  Sits between transmit and the IF stage of the MIPS pipeline.
// PARAMETERS
//  IWIDTH  32  instruction word width
//  DEPTH   6   buffer capacity in words (must satisfy DEPTH <= 2**AWIDTH)
//  AWIDTH  3   buffer address width
// PORTS
//  r_clk      in   1         clock, all logic on posedge
//  r_rst      in   1         reset, synchronous, active-high
//  r_i_start  in   1         pulse: begin a new load
//  r_i_instr  in   IWIDTH    instruction word from transmit
//  r_i_ack    in   1         r_i_instr valid this cycle
//  r_i_last   in   1         qualifies r_i_ack: final word of program
//  r_o_syn    out  1         request to transmit, high while loading
//  r_i_raddr  in   AWIDTH    fetch read address (word index)
//  r_o_rdata  out  IWIDTH    read data, 1-cycle latency
//  r_o_count  out  AWIDTH+1  number of words stored in current load
//  r_o_done   out  1         level: load finished (normal or truncated)
//  r_o_ovf    out  1         level: buffer filled before last seen
// BEHAVIOUR
//  Reset (r_rst=1 at posedge): state IDLE; r_o_syn=0, r_o_count=0, r_o_done=0, r_o_ovf=0,
//   r_o_rdata=0. Buffer contents not cleared. Reset mid-load aborts load; no further writes.
//  FSM states IDLE, LOAD, DONE; all outputs registered.
//  IDLE: syn=0. r_i_start=1 -> LOAD; same edge clears count, done, ovf.
//  LOAD: syn=1 (first high the cycle after start). Per posedge with r_i_ack=1:
//   mem[count]<=r_i_instr, count<=count+1.
//   - ack & last -> DONE; done=1 and syn=0 from next cycle.
//   - ack & !last & count==DEPTH-1 -> word stored, ovf=1, -> DONE (truncated).
//   - ack=0 -> hold; no write, count unchanged. r_i_last ignored without ack.
//   - r_i_start ignored in LOAD.
//  DONE: syn=0, done=1. r_i_start=1 -> LOAD (clears count, done, ovf as in IDLE).
//  r_i_ack outside LOAD ignored: no write, count unchanged.
//  Read port: every posedge r_o_rdata <= (r_i_raddr < r_o_count) ? mem[r_i_raddr] : 0,
//   using pre-edge count; reads legal in any state. Word being written this edge reads 0.
//  count never exceeds DEPTH; no wrap-around.
// TESTING
//  1 Reset 2 cycles -> syn=0, done=0, ovf=0, count=0, rdata=0.
//  2 start; 6 acked words 0x20080001..0x20080006, last on 6th -> count=6, done=1, ovf=0,
//    syn low cycle after last; raddr 0..5 -> rdata 0x20080001..6, one cycle later.
//  3 ack low 2 cycles between words 2 and 3 -> count holds at 2, no duplicate writes, final count=6.
//  4 7 acked words, no last -> count=6, ovf=1, done=1; 7th word not stored, mem[5]=word 6.
//  5 rst high after 3 words -> syn=0, count=0, done=0; restart, 2 words + last -> count=2, done=1.
//  6 count=2, raddr=4 -> rdata=0; ack=1 in DONE -> count stays 2, mem unchanged.

Source files
------------

// File: rtl/receive.sv
// Instruction-stream receiver: requests words from transmit, buffers them until last or full,
// and serves the buffer to fetch through a registered read port.
module receive #(
  parameter int unsigned IWIDTH = 32,
  parameter int unsigned DEPTH  = 6,
  parameter int unsigned AWIDTH = 3
) (
  input  logic              r_clk,
  input  logic              r_rst,
  input  logic              r_i_start,
  input  logic [IWIDTH-1:0] r_i_instr,
  input  logic              r_i_ack,
  input  logic              r_i_last,
  output logic              r_o_syn,
  input  logic [AWIDTH-1:0] r_i_raddr,
  output logic [IWIDTH-1:0] r_o_rdata,
  output logic [AWIDTH:0]   r_o_count,
  output logic              r_o_done,
  output logic              r_o_ovf
);

  typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

  localparam logic [AWIDTH:0] LastIdx = (AWIDTH + 1)'(DEPTH - 1);

  state_e             r_state;
  logic               r_syn;
  logic [AWIDTH:0]    r_count;
  logic               r_done;
  logic               r_ovf;
  logic [IWIDTH-1:0]  r_rdata;
  logic [IWIDTH-1:0]  r_mem [DEPTH];

  state_e             w_state_nxt;
  logic [AWIDTH:0]    w_count_nxt;
  logic               w_done_nxt;
  logic               w_ovf_nxt;
  logic               w_we;
  logic               w_rd_hit;

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_done_nxt  = r_done;
    w_ovf_nxt   = r_ovf;
    w_we        = 1'b0;
    unique case (r_state)
      StIdle, StDone: begin
        if (r_i_start) begin
          w_state_nxt = StLoad;
          w_count_nxt = '0;
          w_done_nxt  = 1'b0;
          w_ovf_nxt   = 1'b0;
        end
      end
      StLoad: begin
        if (r_i_ack) begin
          w_we        = 1'b1;
          w_count_nxt = r_count + 1'b1;
          if (r_i_last) begin
            w_state_nxt = StDone;
            w_done_nxt  = 1'b1;
          end else if (r_count == LastIdx) begin
            // Buffer full without last: truncate the program.
            w_state_nxt = StDone;
            w_done_nxt  = 1'b1;
            w_ovf_nxt   = 1'b1;
          end
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  // Read hit uses the pre-edge count, so the word being written this edge reads as 0.
  assign w_rd_hit = ({1'b0, r_i_raddr} < r_count);

  always_ff @(posedge r_clk) begin
    if (r_rst) begin
      r_state <= StIdle;
      r_syn   <= 1'b0;
      r_count <= '0;
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_syn   <= (w_state_nxt == StLoad);
      r_count <= w_count_nxt;
      r_done  <= w_done_nxt;
      r_ovf   <= w_ovf_nxt;
      r_rdata <= w_rd_hit ? r_mem[r_i_raddr] : '0;
    end
  end

  // Buffer is not cleared by reset; reset only blocks writes.
  always_ff @(posedge r_clk) begin
    if (w_we && !r_rst) begin
      r_mem[r_count[AWIDTH-1:0]] <= r_i_instr;
    end
  end

  assign r_o_syn   = r_syn;
  assign r_o_count = r_count;
  assign r_o_done  = r_done;
  assign r_o_ovf   = r_ovf;
  assign r_o_rdata = r_rdata;

endmodule

// File: tb/tb_receive.sv
// Scoreboard bench for receive: a list-level load model predicts status and read data.
module tb_receive;

  localparam int DEPTH = 6;

  logic        clk = 1'b0;
  logic        rst, start, ack, last;
  logic [31:0] instr;
  logic [2:0]  raddr;
  logic        syn, done, ovf;
  logic [31:0] rdata;
  logic [3:0]  count;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: buffer contents and load status.
  logic [31:0] m_mem [DEPTH];
  int          m_count;
  bit          m_loading, m_done, m_ovf;

  logic [31:0] exp_q  [$];
  int          addr_q [$];
  logic        rd_issue = 1'b0;
  logic        rd_vld   = 1'b0;

  receive dut (
    .r_clk    (clk),
    .r_rst    (rst),
    .r_i_start(start),
    .r_i_instr(instr),
    .r_i_ack  (ack),
    .r_i_last (last),
    .r_o_syn  (syn),
    .r_i_raddr(raddr),
    .r_o_rdata(rdata),
    .r_o_count(count),
    .r_o_done (done),
    .r_o_ovf  (ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rd_vld <= rd_issue;

  // Monitor: every read response is compared against the queued prediction.
  always @(negedge clk) begin
    if (rd_vld) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL rdata_unexpected: got %h, no read pending", rdata);
      end else begin
        logic [31:0] e;
        int          a;
        e = exp_q.pop_front();
        a = addr_q.pop_front();
        if (rdata !== e) begin
          n_errors++;
          $display("FAIL rdata[%0d]: got %h expected %h", a, rdata, e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_status(input string tag);
    chk({tag, ".syn"},   32'(syn),   32'(m_loading));
    chk({tag, ".count"}, 32'(count), 32'(m_count));
    chk({tag, ".done"},  32'(done),  32'(m_done));
    chk({tag, ".ovf"},   32'(ovf),   32'(m_ovf));
  endtask

  function automatic void model_ack(input logic [31:0] w, input bit l);
    if (m_loading) begin
      m_mem[m_count] = w;
      m_count++;
      if (l) begin
        m_loading = 0;
        m_done    = 1;
      end else if (m_count == DEPTH) begin
        m_loading = 0;
        m_done    = 1;
        m_ovf     = 1;
      end
    end
  endfunction

  task automatic do_reset(input string tag);
    rst   = 1'b1;
    ack   = 1'b0;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst       = 1'b0;
    m_loading = 0;
    m_done    = 0;
    m_ovf     = 0;
    m_count   = 0;
    chk_status(tag);
    chk({tag, ".rdata"}, rdata, 32'h0);
  endtask

  // Words are base+1, base+2, ... or random; last_at < 0 means no last flag.
  task automatic load(input string tag, input int n, input int last_at, input logic [31:0] base,
                      input int gap_at, input int gap_len, input bit rnd);
    start = 1'b1;
    @(posedge clk);
    m_loading = 1;
    m_done    = 0;
    m_ovf     = 0;
    m_count   = 0;
    @(negedge clk);
    start = 1'b0;
    chk_status({tag, ".start"});
    for (int i = 0; i < n; i++) begin
      int          g;
      logic [31:0] w;
      g = (i == gap_at) ? gap_len : (rnd ? int'($urandom_range(0, 2)) : 0);
      repeat (g) begin
        ack   = 1'b0;
        last  = 1'($urandom);
        instr = $urandom;
        start = m_loading && rnd ? 1'($urandom) : 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk_status({tag, ".gap"});
      end
      w     = rnd ? $urandom : base + 32'(i + 1);
      ack   = 1'b1;
      instr = w;
      last  = (i == last_at);
      @(posedge clk);
      model_ack(w, i == last_at);
      @(negedge clk);
      ack  = 1'b0;
      last = 1'b0;
      chk_status({tag, ".word"});
    end
  endtask

  task automatic ack_idle(input int k);
    repeat (k) begin
      ack   = 1'b1;
      last  = 1'($urandom);
      instr = $urandom;
      @(posedge clk);
      model_ack(instr, 1'b0);
      @(negedge clk);
      ack = 1'b0;
      chk_status("idle_ack");
    end
  endtask

  task automatic read_all();
    for (int a = 0; a < 8; a++) begin
      raddr    = 3'(a);
      rd_issue = 1'b1;
      exp_q.push_back((a < m_count) ? m_mem[a] : 32'h0);
      addr_q.push_back(a);
      @(posedge clk);
      @(negedge clk);
    end
    rd_issue = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    ack   = 1'b0;
    last  = 1'b0;
    instr = '0;
    raddr = '0;
    @(negedge clk);
    do_reset("reset");

    load("basic", 6, 5, 32'h2008_0000, -1, 0, 1'b0);
    read_all();

    load("gap", 6, 5, 32'h3008_0000, 2, 2, 1'b0);
    read_all();

    load("ovf", 7, -1, 32'h4008_0000, -1, 0, 1'b0);
    read_all();

    load("abort", 3, -1, 32'h5008_0000, -1, 0, 1'b0);
    do_reset("midrst");
    load("restart", 2, 1, 32'h6008_0000, -1, 0, 1'b0);
    ack_idle(3);
    read_all();

    for (int it = 0; it < 25; it++) begin
      int n;
      int r;
      n = int'($urandom_range(1, 8));
      r = int'($urandom_range(0, n));
      load("rand", n, (r == n) ? -1 : r, 32'h0, -1, 0, 1'b1);
      if (m_loading) do_reset("rand_rst");
      read_all();
    end

    repeat (3) @(negedge clk);
    chk("drain", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
